// File: rtl/mem_nb_stage_pkg.sv
// Shared widths, defaults and the entry payload for the non-blocking MEM stage.
package mem_nb_stage_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned LSEL_W        = 4;
    localparam int unsigned GPR_W         = 5;
    localparam int unsigned EXC_W         = 5;
    localparam int unsigned MEM_NB_DEPTH  = 4;
    localparam int unsigned MEM_NB_MAXOUT = 8;

    typedef struct packed {
        logic [GPR_W-1:0]  write_num;
        logic              mem_req;
        logic [LSEL_W-1:0] load_sel;
        logic [DATA_W-1:0] res;
        logic              has_exc;
        logic [EXC_W-1:0]  exc_code;
    } mem_entry_t;

endpackage

// File: rtl/mem_entry_ring.sv
// In-order entry ring: payload storage, head/tail pointers, occupancy and
// per-entry valid/waiting/done state; responses land in the oldest waiting entry.
module mem_entry_ring
    import mem_nb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_NB_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic                    rsp_i,
    input  mem_entry_t              push_entry_i,
    input  logic [DATA_W-1:0]       rsp_data_i,
    output mem_entry_t              head_entry_o,
    output logic [DATA_W-1:0]       head_rdata_o,
    output logic                    head_ready_o,
    output logic                    rsp_found_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [$clog2(DEPTH):0]  pending_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, rsp_ptr;
    logic [PTR_W-1:0]  scan_idx;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d, waiting_q, waiting_d, done_q, done_d;
    mem_entry_t        mem_q [DEPTH];
    mem_entry_t        mem_d [DEPTH];
    logic [DATA_W-1:0] rdata_q [DEPTH];
    logic [DATA_W-1:0] rdata_d [DEPTH];

    // Oldest live entry still owed a response; lowest offset from head wins.
    always_comb begin
        rsp_found_o = 1'b0;
        rsp_ptr     = head_q;
        scan_idx    = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            scan_idx = head_q + PTR_W'(i);
            if (valid_q[scan_idx] && waiting_q[scan_idx] && !done_q[scan_idx]) begin
                rsp_found_o = 1'b1;
                rsp_ptr     = scan_idx;
            end
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            pending_o = pending_o + CNT_W'(valid_q[i] & waiting_q[i] & ~done_q[i]);
        end
    end

    assign head_entry_o = mem_q[head_q];
    assign head_rdata_o = rdata_q[head_q];
    assign head_ready_o = valid_q[head_q] && (!waiting_q[head_q] || done_q[head_q]);
    assign count_o      = count_q;

    // Pop clears the head before push writes the tail, so full push+pop reuses the slot.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        waiting_d = waiting_q;
        done_d    = done_q;
        mem_d     = mem_q;
        rdata_d   = rdata_q;
        if (flush_i) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            valid_d   = '0;
            waiting_d = '0;
            done_d    = '0;
        end else begin
            if (rsp_i && rsp_found_o) begin
                done_d[rsp_ptr]  = 1'b1;
                rdata_d[rsp_ptr] = rsp_data_i;
            end
            if (pop_i) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PTR_W'(1);
            end
            if (push_i) begin
                valid_d[tail_q]   = 1'b1;
                waiting_d[tail_q] = push_entry_i.mem_req && !push_entry_i.has_exc;
                done_d[tail_q]    = 1'b0;
                mem_d[tail_q]     = push_entry_i;
                tail_d            = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            waiting_q <= '0;
            done_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i]   <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            waiting_q <= waiting_d;
            done_q    <= done_d;
            mem_q     <= mem_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: rtl/mem_nb_stage.sv
// Non-blocking MEM stage: ring of in-flight entries plus drain accounting for
// bus responses still owed to flushed requests.
module mem_nb_stage
    import mem_nb_stage_pkg::*;
#(
    parameter int unsigned DEPTH   = MEM_NB_DEPTH,
    parameter int unsigned MAX_OUT = MEM_NB_MAXOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    PREMEM_valid_i,
    output logic                    MEM_allowin_o,
    input  logic [GPR_W-1:0]        PREMEM_writeNum_i,
    input  logic                    PREMEM_memReq_i,
    input  logic [LSEL_W-1:0]       PREMEM_loadSel_i,
    input  logic [DATA_W-1:0]       PREMEM_res_i,
    input  logic                    PREMEM_hasExc_i,
    input  logic [EXC_W-1:0]        PREMEM_excCode_i,
    input  logic                    data_data_ok,
    input  logic [DATA_W-1:0]       data_rdata,
    input  logic                    flush_i,
    input  logic                    WB_allowin_i,
    output logic                    MEM_valid_o,
    output logic [GPR_W-1:0]        MEM_writeNum_o,
    output logic [LSEL_W-1:0]       MEM_loadSel_o,
    output logic [DATA_W-1:0]       MEM_finalRes_o,
    output logic                    MEM_hasExc_o,
    output logic [EXC_W-1:0]        MEM_excCode_o,
    output logic [$clog2(DEPTH):0]  MEM_count_o,
    output logic                    MEM_busy_o,
    output logic                    MEM_rspErr_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned DRN_W = $clog2(MAX_OUT + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUT + DEPTH + 1);

    logic              push_c, pop_c, rsp_c, head_ready, rsp_found;
    logic [CNT_W-1:0]  count, pending;
    logic [OUT_W-1:0]  owed;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] head_rdata;
    mem_entry_t        head_entry, push_entry;

    assign push_entry = '{write_num: PREMEM_writeNum_i, mem_req: PREMEM_memReq_i,
                          load_sel: PREMEM_loadSel_i, res: PREMEM_res_i,
                          has_exc: PREMEM_hasExc_i, exc_code: PREMEM_excCode_i};

    mem_entry_ring #(.DEPTH(DEPTH)) u_ring (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_c),
        .pop_i        (pop_c),
        .flush_i      (flush_i),
        .rsp_i        (rsp_c),
        .push_entry_i (push_entry),
        .rsp_data_i   (data_rdata),
        .head_entry_o (head_entry),
        .head_rdata_o (head_rdata),
        .head_ready_o (head_ready),
        .rsp_found_o  (rsp_found),
        .count_o      (count),
        .pending_o    (pending)
    );

    // owed = every response the bus still has to deliver (draining + live waiters).
    assign owed          = OUT_W'(drain_q) + OUT_W'(pending);
    assign MEM_valid_o   = head_ready && !flush_i;
    assign pop_c         = MEM_valid_o && WB_allowin_i;
    assign MEM_allowin_o = (count < CNT_W'(DEPTH) || pop_c) && (owed < OUT_W'(MAX_OUT));
    assign push_c        = PREMEM_valid_i && MEM_allowin_o && !flush_i;

    assign MEM_writeNum_o = MEM_valid_o ? head_entry.write_num : '0;
    assign MEM_loadSel_o  = MEM_valid_o ? head_entry.load_sel  : '0;
    assign MEM_hasExc_o   = MEM_valid_o && head_entry.has_exc;
    assign MEM_excCode_o  = MEM_valid_o ? head_entry.exc_code  : '0;
    assign MEM_finalRes_o = !MEM_valid_o ? '0 :
                            (head_entry.mem_req && !head_entry.has_exc) ? head_rdata : head_entry.res;
    assign MEM_count_o    = count;
    assign MEM_busy_o     = (count != '0) || (drain_q != '0);
    assign MEM_rspErr_o   = rsp_err_q;

    // Response routing: drain first, then the ring, otherwise an unowed response.
    always_comb begin
        drain_d   = drain_q;
        rsp_err_d = rsp_err_q;
        rsp_c     = 1'b0;
        if (flush_i) begin
            if (data_data_ok) begin
                if (owed != '0) begin
                    drain_d = DRN_W'(owed - OUT_W'(1));
                end else begin
                    drain_d   = DRN_W'(owed);
                    rsp_err_d = 1'b1;
                end
            end else begin
                drain_d = DRN_W'(owed);
            end
        end else if (data_data_ok) begin
            if (drain_q != '0) begin
                drain_d = drain_q - DRN_W'(1);
            end else begin
                rsp_c = 1'b1;
                if (!rsp_found) begin
                    rsp_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            drain_q   <= drain_d;
            rsp_err_q <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_nb_stage.sv
// Directed bench for mem_nb_stage against a queue-based model of the stage.
module tb_mem_nb_stage;
    import mem_nb_stage_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              PREMEM_valid_i, PREMEM_memReq_i, PREMEM_hasExc_i;
    logic [GPR_W-1:0]  PREMEM_writeNum_i;
    logic [LSEL_W-1:0] PREMEM_loadSel_i;
    logic [DATA_W-1:0] PREMEM_res_i, data_rdata;
    logic [EXC_W-1:0]  PREMEM_excCode_i;
    logic              data_data_ok, flush_i, WB_allowin_i;
    logic              MEM_allowin_o, MEM_valid_o, MEM_hasExc_o, MEM_busy_o, MEM_rspErr_o;
    logic [GPR_W-1:0]  MEM_writeNum_o;
    logic [LSEL_W-1:0] MEM_loadSel_o;
    logic [DATA_W-1:0] MEM_finalRes_o;
    logic [EXC_W-1:0]  MEM_excCode_o;
    logic [2:0]        MEM_count_o;

    mem_nb_stage #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .PREMEM_valid_i(PREMEM_valid_i), .MEM_allowin_o(MEM_allowin_o),
        .PREMEM_writeNum_i(PREMEM_writeNum_i), .PREMEM_memReq_i(PREMEM_memReq_i),
        .PREMEM_loadSel_i(PREMEM_loadSel_i), .PREMEM_res_i(PREMEM_res_i),
        .PREMEM_hasExc_i(PREMEM_hasExc_i), .PREMEM_excCode_i(PREMEM_excCode_i),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush_i(flush_i),
        .WB_allowin_i(WB_allowin_i), .MEM_valid_o(MEM_valid_o),
        .MEM_writeNum_o(MEM_writeNum_o), .MEM_loadSel_o(MEM_loadSel_o),
        .MEM_finalRes_o(MEM_finalRes_o), .MEM_hasExc_o(MEM_hasExc_o),
        .MEM_excCode_o(MEM_excCode_o), .MEM_count_o(MEM_count_o),
        .MEM_busy_o(MEM_busy_o), .MEM_rspErr_o(MEM_rspErr_o)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [GPR_W-1:0]  wn;
        logic [LSEL_W-1:0] lsel;
        logic [DATA_W-1:0] res;
        logic              exc;
        logic [EXC_W-1:0]  code;
        bit                wt;
        bit                dn;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              q[$];
    logic [DATA_W-1:0] rlog[$];
    int                m_drain = 0;
    bit                m_err = 0;
    bit                m_pop, m_push;
    int                n_chk = 0;
    int                n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Expected outputs from the model for the current state and inputs.
    task automatic check_cycle();
        int pend = 0;
        bit ready, v, ain;
        foreach (q[i]) if (q[i].wt && !q[i].dn) pend++;
        ready = (q.size() > 0) && (!q[0].wt || q[0].dn);
        v     = ready && !flush_i;
        m_pop = v && WB_allowin_i;
        ain   = ((q.size() < DEPTH) || m_pop) && ((m_drain + pend) < MAX_OUT);
        m_push = PREMEM_valid_i && ain && !flush_i;
        chk("valid",   64'(MEM_valid_o),   64'(v));
        chk("allowin", 64'(MEM_allowin_o), 64'(ain));
        chk("count",   64'(MEM_count_o),   64'(q.size()));
        chk("busy",    64'(MEM_busy_o),    64'(q.size() != 0 || m_drain != 0));
        chk("rsp_err", 64'(MEM_rspErr_o),  64'(m_err));
        if (v) begin
            chk("writeNum", 64'(MEM_writeNum_o), 64'(q[0].wn));
            chk("loadSel",  64'(MEM_loadSel_o),  64'(q[0].lsel));
            chk("finalRes", 64'(MEM_finalRes_o), 64'(q[0].wt ? q[0].data : q[0].res));
            chk("hasExc",   64'(MEM_hasExc_o),   64'(q[0].exc));
            chk("excCode",  64'(MEM_excCode_o),  64'(q[0].code));
            if (WB_allowin_i) rlog.push_back(MEM_finalRes_o);
        end
    endtask

    task automatic model_step();
        int owed;
        int first = -1;
        ent_t e;
        if (flush_i) begin
            owed = m_drain;
            foreach (q[i]) if (q[i].wt && !q[i].dn) owed++;
            if (data_data_ok) begin
                if (owed > 0) owed--;
                else m_err = 1;
            end
            m_drain = owed;
            q.delete();
        end else begin
            if (data_data_ok) begin
                if (m_drain > 0) m_drain--;
                else begin
                    for (int i = 0; i < q.size(); i++)
                        if (q[i].wt && !q[i].dn) begin first = i; break; end
                    if (first >= 0) begin
                        q[first].dn   = 1;
                        q[first].data = data_rdata;
                    end else m_err = 1;
                end
            end
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                e.wn = PREMEM_writeNum_i; e.lsel = PREMEM_loadSel_i; e.res = PREMEM_res_i;
                e.exc = PREMEM_hasExc_i; e.code = PREMEM_excCode_i;
                e.wt = PREMEM_memReq_i && !PREMEM_hasExc_i; e.dn = 0; e.data = '0;
                q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_in();
        PREMEM_valid_i = 0; PREMEM_memReq_i = 0; PREMEM_hasExc_i = 0;
        PREMEM_writeNum_i = '0; PREMEM_loadSel_i = '0; PREMEM_res_i = '0; PREMEM_excCode_i = '0;
        data_data_ok = 0; data_rdata = '0; flush_i = 0; WB_allowin_i = 1;
    endtask

    task automatic push_op(input int wn, input bit mr, input int res, input bit exc, input int code);
        PREMEM_valid_i = 1; PREMEM_writeNum_i = GPR_W'(wn); PREMEM_memReq_i = mr;
        PREMEM_loadSel_i = LSEL_W'(wn + 1); PREMEM_res_i = DATA_W'(res);
        PREMEM_hasExc_i = exc; PREMEM_excCode_i = EXC_W'(code);
    endtask

    task automatic rsp(input int d);
        data_data_ok = 1; data_rdata = DATA_W'(d);
    endtask

    initial begin
        clear_in();
        rst = 0;
        #5;
        chk("rst_valid",   64'(MEM_valid_o),   64'(0));
        chk("rst_allowin", 64'(MEM_allowin_o), 64'(1));
        chk("rst_count",   64'(MEM_count_o),   64'(0));
        chk("rst_busy",    64'(MEM_busy_o),    64'(0));
        #20 rst = 1;
        @(posedge clk); #1;

        // ALU-only stream: each entry retires the cycle after its push
        rlog.delete();
        for (int i = 0; i < 6; i++) begin clear_in(); push_op(i + 1, 0, 'h100 + i, 0, 0); tick(); end
        clear_in(); tick();
        chk("alu_n",    64'(rlog.size()), 64'(6));
        chk("alu_first", 64'(rlog[0]), 64'h100);
        chk("alu_last",  64'(rlog[5]), 64'h105);

        // Four loads fill the ring, responses retire them in order
        rlog.delete();
        for (int i = 0; i < 4; i++) begin clear_in(); push_op(i + 1, 1, 'hdead, 0, 0); tick(); end
        clear_in(); #1;
        chk("full_count",   64'(MEM_count_o),   64'(4));
        chk("full_allowin", 64'(MEM_allowin_o), 64'(0));
        for (int i = 0; i < 4; i++) begin clear_in(); rsp('hA + i); tick(); end
        clear_in(); tick();
        chk("ld_n", 64'(rlog.size()), 64'(4));
        chk("ld_0", 64'(rlog[0]), 64'hA);
        chk("ld_3", 64'(rlog[3]), 64'hD);
        clear_in(); #1;
        chk("ld_allowin", 64'(MEM_allowin_o), 64'(1));

        // Push into a full ring while the head pops
        rlog.delete();
        for (int i = 0; i < 4; i++) begin clear_in(); WB_allowin_i = 0; push_op(i + 1, 0, 'h200 + i, 0, 0); tick(); end
        clear_in(); push_op(9, 0, 'h204, 0, 0); tick();
        clear_in(); WB_allowin_i = 0; #1;
        chk("wrap_count", 64'(MEM_count_o), 64'(4));
        for (int i = 0; i < 4; i++) begin clear_in(); tick(); end
        chk("wrap_n",    64'(rlog.size()), 64'(5));
        chk("wrap_last", 64'(rlog[4]), 64'h204);

        // Flush with three loads pending, then a new load matched after the drain
        rlog.delete();
        for (int i = 0; i < 3; i++) begin clear_in(); push_op(i + 1, 1, 'h300, 0, 0); tick(); end
        clear_in(); flush_i = 1; tick();
        clear_in(); #1;
        chk("fl_drain", 64'(m_drain), 64'(3));
        chk("fl_count", 64'(MEM_count_o), 64'(0));
        chk("fl_busy",  64'(MEM_busy_o),  64'(1));
        clear_in(); push_op(7, 1, 'h77, 0, 0); tick();
        for (int i = 1; i <= 3; i++) begin clear_in(); rsp(i); tick(); end
        clear_in(); rsp('h55); tick();
        clear_in(); tick();
        chk("drain_n",   64'(rlog.size()), 64'(1));
        chk("drain_res", 64'(rlog[0]), 64'h55);

        // Flush coinciding with a response
        for (int i = 0; i < 2; i++) begin clear_in(); push_op(i + 2, 1, 'h400, 0, 0); tick(); end
        clear_in(); flush_i = 1; rsp('h9); tick();
        clear_in(); #1;
        chk("fl_ok_drain", 64'(m_drain), 64'(1));
        clear_in(); rsp('h8); tick();
        clear_in(); #1;
        chk("fl_ok_busy", 64'(MEM_busy_o), 64'(0));

        // Excepting load retires without a response; a spurious response is sticky
        rlog.delete();
        clear_in(); push_op(3, 1, 'h66, 1, 4); tick();
        clear_in(); tick();
        chk("exc_res", 64'(rlog[0]), 64'h66);
        clear_in(); rsp('h1); tick();
        clear_in(); tick(); tick();
        chk("err_sticky", 64'(MEM_rspErr_o), 64'(1));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 2; i++) begin clear_in(); push_op(i + 4, 1, 'h500, 0, 0); tick(); end
        clear_in();
        #2 rst = 0;
        #1;
        chk("ar_valid",   64'(MEM_valid_o),   64'(0));
        chk("ar_allowin", 64'(MEM_allowin_o), 64'(1));
        chk("ar_count",   64'(MEM_count_o),   64'(0));
        chk("ar_busy",    64'(MEM_busy_o),    64'(0));
        chk("ar_err",     64'(MEM_rspErr_o),  64'(0));
        q.delete(); m_drain = 0; m_err = 0;
        #2 rst = 1;
        clear_in(); push_op(1, 0, 'h600, 0, 0); tick();
        clear_in(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
